// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8-bit serial transmitter, MSB first, one start and one stop bit.
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   : frame = start, 8 data, even parity, stop (11 bit periods)
//   undefined : frame = start, 8 data, stop              (10 bit periods)
//
// Parameters:
//   CLKS_PER_BIT  sys_clk cycles per serial bit (2..255)
//
// Ports:
//   sys_clk     in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   tx_data     in   [7:0] byte to send, latched on acceptance
//   tx_valid    in   request to send tx_data
//   tx_ready    out  registered; high only in IDLE, byte accepted when
//                    tx_valid && tx_ready on a rising edge
//   TX          out  registered serial line, idles high
//   busy        out  registered; high while a frame is on the line
//   frame_done  out  registered one-cycle pulse after the stop bit
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_end;

    assign TX         = tx_q;
    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bit_end = (bit_cnt_q == BIT_LAST);

    // All outputs are registered, so each transition computes the value the
    // line must carry during the *next* bit period.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
                bit_idx_d = '0;
                ready_d   = 1'b1;
                if (tx_valid && ready_q) begin
                    state_d = START;
                    shift_d = tx_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[7];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Bit currently on the line is 7-idx; the next one is 6-idx.
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[3'd6 - bit_idx_q];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
